// File: rtl/mmio_periph.sv
// Memory-mapped timer/PWM peripheral: free-running millis/micros counters and a
// four-channel 8-bit PWM with a double-buffered duty word, 1-cycle registered reads.
module mmio_periph #(
  parameter int unsigned CLK_FREQ_HZ = 12000000,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFFFFF4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  funct3,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  output logic [31:0] dmem_data_out,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam int unsigned US_DIV  = (CLK_FREQ_HZ / 1000000 > 0) ? CLK_FREQ_HZ / 1000000 : 1;
  localparam int unsigned US_W    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned MS_DIV  = 1000;
  localparam int unsigned MS_W    = 10;
  localparam int unsigned WORDS   = 3;
  localparam logic [US_W-1:0] US_LAST = US_W'(US_DIV - 1);
  localparam logic [MS_W-1:0] MS_LAST = MS_W'(MS_DIV - 1);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [US_W-1:0] us_pre;
  logic [MS_W-1:0] ms_pre;
  logic [31:0]     micros;
  logic [31:0]     millis;
  logic [7:0]      pwm_cnt;
  logic [31:0]     duty_shadow;
  logic [31:0]     duty_active;

  logic [31:0] offset;
  logic        in_win;
  logic [1:0]  word_sel;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_data;
  logic [31:0] shadow_nxt;
  logic        us_tick;
  logic        ms_tick;

  // Unsigned offset compare keeps the window correct even when it touches 2^32.
  assign offset   = dmem_address - BASE_ADDR;
  assign in_win   = offset < 32'(WORDS * 4);
  assign word_sel = offset[3:2];

  assign us_tick = (us_pre == US_LAST);
  assign ms_tick = us_tick && (ms_pre == MS_LAST);

  // Load path: select word, then lane, then size/sign extension.
  always_comb begin
    rd_word = '0;
    if (in_win) begin
      case (word_sel)
        2'd0:    rd_word = millis;
        2'd1:    rd_word = micros;
        2'd2:    rd_word = duty_shadow;
        default: rd_word = '0;
      endcase
    end
    case (dmem_address[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = dmem_address[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct3)
      F3_B:    rd_data = {{24{rd_byte[7]}}, rd_byte};
      F3_H:    rd_data = {{16{rd_half[15]}}, rd_half};
      F3_BU:   rd_data = {24'd0, rd_byte};
      F3_HU:   rd_data = {16'd0, rd_half};
      default: rd_data = rd_word;
    endcase
  end

  // Store path: lane-merged shadow duty word; only the duty register is writable.
  always_comb begin
    shadow_nxt = duty_shadow;
    if (dmem_wren && in_win && (word_sel == 2'd2)) begin
      case (funct3)
        F3_B, F3_BU: shadow_nxt[{dmem_address[1:0], 3'b000} +: 8] = dmem_data_in[7:0];
        F3_H, F3_HU: begin
          if (dmem_address[1]) shadow_nxt[31:16] = dmem_data_in[15:0];
          else                 shadow_nxt[15:0]  = dmem_data_in[15:0];
        end
        F3_W:    shadow_nxt = dmem_data_in;
        default: shadow_nxt = duty_shadow;
      endcase
    end
  end

  // Timebase: clock prescaler -> micros, micro prescaler -> millis.
  always_ff @(posedge clk) begin
    if (reset) begin
      us_pre <= '0;
      ms_pre <= '0;
      micros <= '0;
      millis <= '0;
    end else begin
      us_pre <= us_tick ? '0 : us_pre + US_W'(1);
      if (us_tick) begin
        micros <= micros + 32'd1;
        ms_pre <= (ms_pre == MS_LAST) ? '0 : ms_pre + MS_W'(1);
      end
      if (ms_tick) millis <= millis + 32'd1;
    end
  end

  // PWM and bus registers; the active duty reloads at count 255 so it applies from count 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt       <= '0;
      duty_shadow   <= '0;
      duty_active   <= '0;
      dmem_data_out <= '0;
      led           <= 1'b0;
      red           <= 1'b0;
      green         <= 1'b0;
      blue          <= 1'b0;
    end else begin
      pwm_cnt       <= pwm_cnt + 8'd1;
      duty_shadow   <= shadow_nxt;
      if (pwm_cnt == 8'hFF) duty_active <= shadow_nxt;
      dmem_data_out <= rd_data;
      led           <= pwm_cnt < duty_active[7:0];
      red           <= pwm_cnt < duty_active[15:8];
      green         <= pwm_cnt < duty_active[23:16];
      blue          <= pwm_cnt < duty_active[31:24];
    end
  end

endmodule
